// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Keeps the state encoding, index width and winner search in one place.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    ADDR    = 3'd2,
    DATA    = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  localparam int MAX_DEV = 16;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First requester found scanning circularly upward from ptr; n is the
  // number of live request bits (1..MAX_DEV).
  function automatic int rr_pick(input logic [MAX_DEV-1:0] req, input int ptr, input int n);
    int  win;
    int  idx;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_DEV; i++) begin
      idx = (ptr + i) % n;
      if (i < n && !found && req[idx[3:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/err_sat_counter.sv
// Per-master saturating error counter; synchronous clear wins over increment.
module err_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         sclr,
  input  logic         ena,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= '0;
    end else if (sclr) begin
      q <= '0;
    end else if (ena && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with address/target-ready watchdogs, burst limit
// and per-master saturating error counters.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter  int DEV_NUM    = 4,
  parameter  int ERR_W      = 8,
  parameter  int AV_TIMEOUT = 16,
  parameter  int TR_TIMEOUT = 32,
  parameter  int MAX_BURST  = 64,
  localparam int IDX_W      = idx_w(DEV_NUM)
) (
  input  logic                            clk,
  input  logic                            clrn,
  input  logic                            sclr,
  input  logic [DEV_NUM-1:0]              BARQ,
  output logic [DEV_NUM-1:0]              BAGD,
  input  logic                            AddressValid,
  input  logic                            TargetReady,
  input  logic                            DataStrobe,
  output logic [IDX_W-1:0]                Owner,
  output logic                            BusBusy,
  output logic                            TimeoutPulse,
  output logic [DEV_NUM-1:0][ERR_W-1:0]   Error
);

  localparam int TMR_LIM = (AV_TIMEOUT > TR_TIMEOUT) ? AV_TIMEOUT : TR_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_LIM) + 1;
  localparam int BEAT_W  = $clog2(MAX_BURST) + 1;

  arb_state_t          state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [DEV_NUM-1:0]  bagd_q, bagd_d;
  logic                tmo_q, tmo_d;
  logic                tmo_ev;
  logic                rel;
  logic                own_req;
  logic [IDX_W-1:0]    win;

  assign own_req = BARQ[owner_q];
  assign win     = IDX_W'(rr_pick(MAX_DEV'(BARQ), int'(ptr_q), DEV_NUM));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    beat_d  = beat_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    bagd_d  = bagd_q;
    tmo_ev  = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|BARQ) begin
          owner_d      = win;
          bagd_d       = '0;
          bagd_d[win]  = 1'b1;
          timer_d      = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (AddressValid) begin
          state_d = ADDR;
          timer_d = '0;
        end else if (!own_req) begin
          rel = 1'b1;
        end else if (timer_q == TMR_W'(AV_TIMEOUT - 1)) begin
          rel    = 1'b1;
          tmo_ev = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ADDR: begin
        if (TargetReady) begin
          state_d = DATA;
          beat_d  = '0;
        end else if (timer_q == TMR_W'(TR_TIMEOUT - 1)) begin
          rel    = 1'b1;
          tmo_ev = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (!own_req || (DataStrobe && (beat_q == BEAT_W'(MAX_BURST - 1)))) begin
          rel = 1'b1;
        end else if (DataStrobe) begin
          beat_d = beat_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Grant drops on the release edge; the pointer moves past the old owner.
    if (rel) begin
      state_d = RELEASE;
      bagd_d  = '0;
      ptr_d   = (owner_q == IDX_W'(DEV_NUM - 1)) ? '0 : owner_q + 1'b1;
    end
    tmo_d = tmo_ev;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      timer_q <= '0;
      beat_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      bagd_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      bagd_q  <= bagd_d;
      tmo_q   <= tmo_d;
    end
  end

  for (genvar i = 0; i < DEV_NUM; i++) begin : g_err
    err_sat_counter #(.W(ERR_W)) u_cnt (
      .clk  (clk),
      .clrn (clrn),
      .sclr (sclr),
      .ena  (tmo_ev && (owner_q == IDX_W'(i))),
      .q    (Error[i])
    );
  end

  assign BAGD         = bagd_q;
  assign BusBusy      = |bagd_q;
  assign Owner        = owner_q;
  assign TimeoutPulse = tmo_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: vector table, directed corner
// sequences and randomized traffic against a phase-level reference model.
module tb_bus_arbiter_rr;

  localparam int N   = 4;
  localparam int EW  = 8;
  localparam int AVT = 16;
  localparam int TRT = 32;
  localparam int MB  = 64;

  logic                 clk = 1'b0;
  logic                 clrn = 1'b0;
  logic                 sclr = 1'b0;
  logic [N-1:0]         BARQ = '0;
  logic [N-1:0]         BAGD;
  logic                 AddressValid = 1'b0;
  logic                 TargetReady = 1'b0;
  logic                 DataStrobe = 1'b0;
  logic [1:0]           Owner;
  logic                 BusBusy;
  logic                 TimeoutPulse;
  logic [N-1:0][EW-1:0] Error;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .DEV_NUM(N), .ERR_W(EW), .AV_TIMEOUT(AVT), .TR_TIMEOUT(TRT), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .clrn(clrn), .sclr(sclr), .BARQ(BARQ), .BAGD(BAGD),
    .AddressValid(AddressValid), .TargetReady(TargetReady), .DataStrobe(DataStrobe),
    .Owner(Owner), .BusBusy(BusBusy), .TimeoutPulse(TimeoutPulse), .Error(Error)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 waiting for address, 2 waiting for
  // target, 3 data transfer, 4 mandatory gap after a release.
  int m_ph, m_owner, m_ptr, m_waited, m_beats;
  int m_err[N];
  int m_tmo;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = 0; m_owner = 0; m_ptr = 0; m_waited = 0; m_beats = 0; m_tmo = 0;
    for (int i = 0; i < N; i++) m_err[i] = 0;
  endtask

  task automatic m_release(input int timed_out);
    m_ph  = 4;
    m_ptr = (m_owner + 1) % N;
    if (timed_out != 0) begin
      m_tmo = 1;
      if (m_err[m_owner] < (1 << EW) - 1) m_err[m_owner]++;
    end
  endtask

  task automatic m_step();
    int found;
    m_tmo = 0;
    case (m_ph)
      0: begin
        found = 0;
        for (int k = 0; k < N; k++)
          if (!found && BARQ[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N; found = 1;
          end
        if (found) begin m_ph = 1; m_waited = 0; end
      end
      1: begin
        if (AddressValid) begin m_ph = 2; m_waited = 0; end
        else if (!BARQ[m_owner]) m_release(0);
        else begin
          m_waited++;
          if (m_waited == AVT) m_release(1);
        end
      end
      2: begin
        if (TargetReady) begin m_ph = 3; m_beats = 0; end
        else begin
          m_waited++;
          if (m_waited == TRT) m_release(1);
        end
      end
      3: begin
        if (DataStrobe) m_beats++;
        if (!BARQ[m_owner] || m_beats == MB) m_release(0);
      end
      default: m_ph = 0;
    endcase
    if (sclr) for (int i = 0; i < N; i++) m_err[i] = 0;
  endtask

  task automatic cmp_all();
    int busy;
    busy = (m_ph >= 1 && m_ph <= 3) ? 1 : 0;
    chk("m_bagd", int'(BAGD), busy ? (1 << m_owner) : 0);
    chk("m_busy", int'(BusBusy), busy);
    chk("m_tmo", int'(TimeoutPulse), m_tmo);
    if (busy != 0) chk("m_owner", int'(Owner), m_owner);
    for (int i = 0; i < N; i++) chk("m_err", int'(Error[i]), m_err[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    cmp_all();
  endtask

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset();
    clrn = 1'b0; sclr = 1'b0; BARQ = '0;
    AddressValid = 1'b0; TargetReady = 1'b0; DataStrobe = 1'b0;
    m_reset();
    #1 cmp_all();
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic wait_grant(output int who, output int n);
    who = -1; n = 0;
    for (int k = 0; k < 8; k++) begin
      if (who < 0) begin
        tick(); n++;
        if (BAGD != 0) who = int'(Owner);
      end
    end
    if (who < 0) chk("grant_wait_expired", 0, 1);
  endtask

  typedef struct {
    logic [N-1:0] barq;
    logic         av, tr, ds;
    logic [N-1:0] e_bagd;
    int           e_owner;
  } vec_t;

  vec_t vt[14];
  int   who, n;
  int   rr_exp[5];

  initial begin
    vt[0]  = '{4'b0100, 0, 0, 0, 4'b0100, 2};
    vt[1]  = '{4'b0100, 1, 0, 0, 4'b0100, 2};
    vt[2]  = '{4'b0100, 0, 1, 0, 4'b0100, 2};
    vt[3]  = '{4'b0100, 0, 0, 1, 4'b0100, 2};
    vt[4]  = '{4'b0100, 0, 0, 1, 4'b0100, 2};
    vt[5]  = '{4'b0100, 0, 0, 1, 4'b0100, 2};
    vt[6]  = '{4'b0000, 0, 0, 0, 4'b0000, 0};
    vt[7]  = '{4'b0000, 0, 0, 0, 4'b0000, 0};
    vt[8]  = '{4'b1111, 0, 0, 0, 4'b1000, 3};
    vt[9]  = '{4'b0111, 0, 0, 0, 4'b0000, 0};
    vt[10] = '{4'b0111, 0, 0, 0, 4'b0000, 0};
    vt[11] = '{4'b0111, 0, 0, 0, 4'b0001, 0};
    vt[12] = '{4'b0000, 0, 0, 0, 4'b0000, 0};
    vt[13] = '{4'b0000, 0, 0, 0, 4'b0000, 0};
    rr_exp = '{0, 1, 2, 3, 0};

    @(negedge clk);
    do_reset();
    chk("reset_bagd", int'(BAGD), 0);

    // Vector table: single grant, release, pointer advance, abandon.
    for (int i = 0; i < 14; i++) begin
      BARQ = vt[i].barq; AddressValid = vt[i].av;
      TargetReady = vt[i].tr; DataStrobe = vt[i].ds;
      tick();
      chk("vec_bagd", int'(BAGD), int'(vt[i].e_bagd));
      if (vt[i].e_bagd != 0) chk("vec_owner", int'(Owner), vt[i].e_owner);
    end

    // Round robin with all masters requesting, each doing one beat.
    do_reset();
    BARQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(who, n);
      chk("rr_order", who, rr_exp[k]);
      if (k > 0) chk("rr_gap", (n >= 2) ? 1 : 0, 1);
      AddressValid = 1'b1; tick(); AddressValid = 1'b0;
      TargetReady = 1'b1; tick(); TargetReady = 1'b0;
      DataStrobe = 1'b1;
      if (who >= 0) BARQ[who] = 1'b0;
      tick();
      chk("rr_release", int'(BAGD), 0);
      DataStrobe = 1'b0; BARQ = 4'b1111;
    end

    // Address-valid watchdog, then target-ready watchdog on master 1.
    do_reset();
    BARQ = 4'b0010;
    wait_grant(who, n);
    chk("av_owner", who, 1);
    repeat (AVT - 1) tick();
    chk("av_hold", int'(BAGD), 2);
    tick();
    chk("av_drop", int'(BAGD), 0);
    chk("av_pulse", int'(TimeoutPulse), 1);
    chk("av_err", int'(Error[1]), 1);
    tick();
    chk("av_pulse_end", int'(TimeoutPulse), 0);
    wait_grant(who, n);
    AddressValid = 1'b1; tick(); AddressValid = 1'b0;
    repeat (TRT - 1) tick();
    chk("tr_hold", int'(BAGD), 2);
    tick();
    chk("tr_drop", int'(BAGD), 0);
    chk("tr_pulse", int'(TimeoutPulse), 1);
    chk("tr_err", int'(Error[1]), 2);

    // Asynchronous reset in the middle of a data phase.
    wait_grant(who, n);
    AddressValid = 1'b1; tick(); AddressValid = 1'b0;
    TargetReady = 1'b1; tick(); TargetReady = 1'b0;
    DataStrobe = 1'b1; tick();
    clrn = 1'b0;
    #1;
    chk("arst_bagd", int'(BAGD), 0);
    chk("arst_busy", int'(BusBusy), 0);
    chk("arst_err", int'(Error[1]), 0);
    do_reset();
    BARQ = 4'b0100;
    tick();
    chk("arst_regrant", int'(BAGD), 4);

    // Burst limit: master 0 strobes every cycle, master 3 waits.
    do_reset();
    BARQ = 4'b1001;
    wait_grant(who, n);
    chk("burst_owner", who, 0);
    AddressValid = 1'b1; tick(); AddressValid = 1'b0;
    TargetReady = 1'b1; tick(); TargetReady = 1'b0;
    DataStrobe = 1'b1;
    repeat (MB - 1) tick();
    chk("burst_hold", int'(BAGD), 1);
    tick();
    chk("burst_drop", int'(BAGD), 0);
    chk("burst_no_tmo", int'(TimeoutPulse), 0);
    DataStrobe = 1'b0;
    wait_grant(who, n);
    chk("burst_next", who, 3);
    chk("burst_err0", int'(Error[0]), 0);

    // Saturation of master 2's counter, then clear coincident with a timeout.
    do_reset();
    BARQ = 4'b0100;
    for (int k = 0; k < 300; k++) begin
      wait_grant(who, n);
      repeat (AVT) tick();
    end
    chk("sat_err", int'(Error[2]), 255);
    wait_grant(who, n);
    repeat (AVT - 1) tick();
    sclr = 1'b1; tick(); sclr = 1'b0;
    chk("sclr_pulse", int'(TimeoutPulse), 1);
    chk("sclr_err", int'(Error[2]), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(7) == 0) BARQ = N'($urandom);
      AddressValid = ($urandom_range(3) == 0);
      TargetReady  = ($urandom_range(2) == 0);
      DataStrobe   = ($urandom_range(1) == 0);
      sclr         = ($urandom_range(199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
